// File: rtl/interval_meter.sv
// Measures the cycles between a start pulse and a stop pulse; the result is held on a valid/ready output.
// Optional INTERVAL_METER_SAT_STOP_EN: a saturated measurement ends itself instead of waiting for stop.
module interval_meter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             overflow,
  output logic             valid,
  input  logic             ready,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_counter;
  logic             r_sat;
  logic [WIDTH-1:0] r_count;
  logic             r_overflow;
  logic             w_maxed;

  assign w_maxed = &r_counter;

  // The counter lags the cycle number by one, so a stop on cycle k reports k-1,
  // which is the value that reloads the timer to the same start-to-done interval.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_counter  <= '0;
      r_sat      <= 1'b0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state   <= RUN;
            r_counter <= '0;
            r_sat     <= 1'b0;
          end
        end
        RUN: begin
          if (start) begin
            r_counter <= '0;
            r_sat     <= 1'b0;
          end else if (stop) begin
            r_state    <= HOLD;
            r_count    <= r_counter;
            r_overflow <= r_sat;
          end else if (!w_maxed) begin
            r_counter <= r_counter + 1'b1;
          end else begin
            r_sat <= 1'b1;
`ifdef INTERVAL_METER_SAT_STOP_EN
            r_state    <= HOLD;
            r_count    <= '1;
            r_overflow <= 1'b1;
`endif
          end
        end
        HOLD: begin
          // A start without ready is dropped; only the handshake cycle may launch a new run.
          if (ready) begin
            if (start) begin
              r_state   <= RUN;
              r_counter <= '0;
              r_sat     <= 1'b0;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign count    = r_count;
  assign overflow = r_overflow;
  assign valid    = (r_state == HOLD);
  assign busy     = (r_state == RUN);

endmodule

// File: tb/tb_interval_meter.sv
// Scoreboard bench for interval_meter: stimulus pushes expected results, a monitor pops them on each handshake.
module tb_interval_meter;

  typedef struct packed {
    logic [7:0] cnt;
    logic       ovf;
  } result_t;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       ready = 1'b1;
  logic [7:0] count;
  logic       overflow;
  logic       valid;
  logic       busy;

  int checks = 0;
  int failures = 0;
  result_t expQ[$];

  interval_meter #(.WIDTH(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start(start), .stop(stop),
    .count(count), .overflow(overflow), .valid(valid), .ready(ready), .busy(busy)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Start on cycle 0 and stop on cycle k; leaves the bench in cycle k+1.
  task automatic applyStimulus(input int k, input logic [7:0] expCnt, input logic expOvf);
    result_t r;
    r.cnt = expCnt;
    r.ovf = expOvf;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (k - 1) tick();
    expQ.push_back(r);
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  // Monitor: every result accepted by the consumer must match the oldest expectation.
  always @(negedge clk_i) begin
    if (rst_ni && valid && ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_valid", 32'd1, 32'd0);
      end else begin
        result_t e;
        e = expQ.pop_front();
        checkOutput("result_count", {24'd0, count}, {24'd0, e.cnt});
        checkOutput("result_overflow", {31'd0, overflow}, {31'd0, e.ovf});
      end
    end
  end

  initial begin
    #2;
    checkOutput("reset_count", {24'd0, count}, 32'd0);
    checkOutput("reset_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("reset_valid", {31'd0, valid}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();

    // Shortest interval: busy only on cycle 1, valid on cycle 2.
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("k1_busy_cycle1", {31'd0, busy}, 32'd1);
    expQ.push_back('{cnt: 8'd0, ovf: 1'b0});
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checkOutput("k1_valid_cycle2", {31'd0, valid}, 32'd1);
    checkOutput("k1_busy_cycle2", {31'd0, busy}, 32'd0);
    tick();
    checkOutput("k1_valid_dropped", {31'd0, valid}, 32'd0);

    applyStimulus(101, 8'd100, 1'b0);
    tick();
    applyStimulus(256, 8'd255, 1'b0);
    tick();
    applyStimulus(257, 8'd255, 1'b1);
    tick();
    applyStimulus(300, 8'd255, 1'b1);
    tick();

    // Result held with ready low; a start during HOLD must be dropped.
    ready = 1'b0;
    applyStimulus(20, 8'd19, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_valid", {31'd0, valid}, 32'd1);
      checkOutput("hold_count", {24'd0, count}, 32'd19);
      checkOutput("hold_busy", {31'd0, busy}, 32'd0);
      start = (i == 2);
      tick();
    end
    start = 1'b0;
    ready = 1'b1;
    tick();
    checkOutput("handshake_valid_drop", {31'd0, valid}, 32'd0);
    checkOutput("handshake_idle_busy", {31'd0, busy}, 32'd0);

    // Start coinciding with the handshake launches a new run immediately.
    applyStimulus(5, 8'd4, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("start_at_handshake_busy", {31'd0, busy}, 32'd1);
    repeat (2) tick();
    expQ.push_back('{cnt: 8'd2, ovf: 1'b0});
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();

    // Restart at cycle 10, stop at cycle 15 -> count 4.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    expQ.push_back('{cnt: 8'd4, ovf: 1'b0});
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();

    // Simultaneous start and stop restarts without producing a result.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    checkOutput("start_stop_busy", {31'd0, busy}, 32'd1);
    checkOutput("start_stop_no_valid", {31'd0, valid}, 32'd0);
    repeat (2) tick();
    expQ.push_back('{cnt: 8'd2, ovf: 1'b0});
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();

    // Reset in the middle of a run clears everything before the next edge.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    rst_ni = 1'b0;
    #1;
    checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset_valid", {31'd0, valid}, 32'd0);
    checkOutput("midreset_count", {24'd0, count}, 32'd0);
    checkOutput("midreset_overflow", {31'd0, overflow}, 32'd0);
    repeat (2) tick();
    rst_ni = 1'b1;
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checkOutput("stop_after_reset_busy", {31'd0, busy}, 32'd0);
    repeat (3) tick();
    checkOutput("stop_after_reset_valid", {31'd0, valid}, 32'd0);

    checkOutput("scoreboard_drained", expQ.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
